// File: rtl/prefetcher_pkg.sv
// Shared constants for the prefetcher: request opcodes, R-transmitter error
// codes and the AXI response encoding.
package prefetcher_pkg;

  localparam logic [2:0] NOP               = 3'd0;
  localparam logic [2:0] READ_REQ_PREF     = 3'd1;
  localparam logic [2:0] READ_REQ_MASTER   = 3'd2;
  localparam logic [2:0] READ_DATA_SLAVE   = 3'd3;
  localparam logic [2:0] READ_DATA_PROMISE = 3'd4;

  typedef enum logic [2:0] {
    TX_ERR_NONE   = 3'd0,
    TX_ERR_ID_OVF = 3'd1,
    TX_ERR_NO_ID  = 3'd2
  } tx_err_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/prefetcher_r_tx_sync_id_fifo.sv
// In-order FIFO of master AR IDs. A push while full is only accepted when a
// pop frees a slot in the same cycle; otherwise the pushed ID is dropped.
module sync_id_fifo #(
  parameter int WIDTH     = 4,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                 do_push, do_pop;

  always_comb begin
    full     = (count_q == DEPTH_CNT);
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + LOG_DEPTH'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
    end
    count_d = count_q + {{LOG_DEPTH{1'b0}}, do_push} - {{LOG_DEPTH{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/prefetcher_r_tx.sv
// AXI R-channel transmitter: pops promised beats from the data queue into a
// 2-entry skid buffer and returns them to the master tagged with in-order IDs.
module prefetcher_r_tx
  import prefetcher_pkg::*;
#(
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int ID_WIDTH             = 4,
  parameter int LOG_ID_DEPTH         = 3
) (
  input  logic                                       clk,
  input  logic                                       resetN,
  input  logic                                       q_valid,
  input  logic [0:((1<<LOG_BLOCK_DATA_BYTES)*8)-1]   q_data,
  input  logic                                       q_last,
  output logic                                       q_pop,
  input  logic                                       ar_push,
  input  logic [0:ID_WIDTH-1]                        ar_id,
  output logic                                       m_rvalid,
  input  logic                                       m_rready,
  output logic [0:((1<<LOG_BLOCK_DATA_BYTES)*8)-1]   m_rdata,
  output logic                                       m_rlast,
  output logic [0:ID_WIDTH-1]                        m_rid,
  output logic [0:1]                                 m_rresp,
  output logic                                       idFull,
  output logic                                       idEmpty,
  output logic [0:2]                                 errorCode
);

  localparam int DATA_BITS = (1 << LOG_BLOCK_DATA_BYTES) * 8;

  logic [0:DATA_BITS-1] buf_data_q [2];
  logic [0:DATA_BITS-1] buf_data_d [2];
  logic                 buf_last_q [2];
  logic                 buf_last_d [2];
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  tx_err_e              err_q, err_d;

  logic                 hs;
  logic                 buf_room;
  logic                 id_full, id_empty, id_pop;
  logic [ID_WIDTH-1:0]  id_head;

  sync_id_fifo #(
    .WIDTH     (ID_WIDTH),
    .LOG_DEPTH (LOG_ID_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (ar_push),
    .pop    (id_pop),
    .din    (ar_id),
    .full   (id_full),
    .empty  (id_empty),
    .head   (id_head)
  );

  // Pop never looks at m_rready, so the master cannot create a comb path into the queue.
  always_comb begin
    buf_room  = (buf_cnt_q != 2'd2);
    q_pop     = q_valid && buf_room && !id_empty;
    m_rvalid  = (buf_cnt_q != 2'd0);
    hs        = m_rvalid && m_rready;
    m_rdata   = buf_data_q[rd_ptr_q];
    m_rlast   = m_rvalid && buf_last_q[rd_ptr_q];
    m_rid     = id_head;
    m_rresp   = AXI_RESP_OKAY;
    idFull    = id_full;
    idEmpty   = id_empty;
    errorCode = err_q;
    id_pop    = hs && m_rlast;

    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (q_pop) begin
      buf_data_d[wr_ptr_q] = q_data;
      buf_last_d[wr_ptr_q] = q_last;
      wr_ptr_d             = !wr_ptr_q;
    end
    if (hs) begin
      rd_ptr_d = !rd_ptr_q;
    end
    buf_cnt_d = buf_cnt_q + {1'b0, q_pop} - {1'b0, hs};

    // Overflow outranks the no-outstanding-burst condition.
    err_d = TX_ERR_NONE;
    if (ar_push && id_full && !id_pop) begin
      err_d = TX_ERR_ID_OVF;
    end else if (q_valid && buf_room && id_empty) begin
      err_d = TX_ERR_NO_ID;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      buf_cnt_q <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_q     <= TX_ERR_NONE;
    end else begin
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_cnt_q  <= buf_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_prefetcher_r_tx.sv
// Directed bench for prefetcher_r_tx: streaming, back-pressure, burst ID
// switching, ID FIFO overflow, missing-ID error and mid-burst reset.
module tb_prefetcher_r_tx;

  logic         clk = 1'b0;
  logic         resetN;
  logic         q_valid;
  logic [0:511] q_data;
  logic         q_last;
  logic         q_pop;
  logic         ar_push;
  logic [0:3]   ar_id;
  logic         m_rvalid;
  logic         m_rready;
  logic [0:511] m_rdata;
  logic         m_rlast;
  logic [0:3]   m_rid;
  logic [0:1]   m_rresp;
  logic         idFull;
  logic         idEmpty;
  logic [0:2]   errorCode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetcher_r_tx dut (
    .clk       (clk),
    .resetN    (resetN),
    .q_valid   (q_valid),
    .q_data    (q_data),
    .q_last    (q_last),
    .q_pop     (q_pop),
    .ar_push   (ar_push),
    .ar_id     (ar_id),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .m_rid     (m_rid),
    .m_rresp   (m_rresp),
    .idFull    (idFull),
    .idEmpty   (idEmpty),
    .errorCode (errorCode)
  );

  function automatic logic [0:511] beat(input int k);
    return 512'(32'hD000_0000 + k);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [3:0] id);
    ar_push = 1'b1;
    ar_id   = id;
    tick();
    ar_push = 1'b0;
  endtask

  // One cycle: drive queue/ready, check outputs mid-cycle, then advance.
  task automatic cyc(input bit qv, input int qi, input bit ql, input bit rr,
                     input bit e_pop, input bit e_rv, input int e_di,
                     input bit e_last, input logic [3:0] e_rid);
    q_valid  = qv;
    q_data   = beat(qi);
    q_last   = ql;
    m_rready = rr;
    #2;
    chk("q_pop", 512'(q_pop), 512'(e_pop));
    chk("m_rvalid", 512'(m_rvalid), 512'(e_rv));
    if (e_rv) begin
      chk("m_rdata", m_rdata, beat(e_di));
      chk("m_rlast", 512'(m_rlast), 512'(e_last));
      chk("m_rid", 512'(m_rid), 512'(e_rid));
    end
    $display("cycle t=%0t qv=%0b pop=%0b rv=%0b rr=%0b rid=%0d last=%0b err=%0d",
             $time, qv, q_pop, m_rvalid, rr, m_rid, m_rlast, errorCode);
    tick();
  endtask

  initial begin
    resetN   = 1'b0;
    q_valid  = 1'b0;
    q_data   = '0;
    q_last   = 1'b0;
    ar_push  = 1'b0;
    ar_id    = '0;
    m_rready = 1'b0;
    tick();

    // Reset state
    chk("rst_m_rvalid", 512'(m_rvalid), 512'(0));
    chk("rst_m_rlast", 512'(m_rlast), 512'(0));
    chk("rst_m_rdata", m_rdata, 512'(0));
    chk("rst_m_rid", 512'(m_rid), 512'(0));
    chk("rst_m_rresp", 512'(m_rresp), 512'(0));
    chk("rst_q_pop", 512'(q_pop), 512'(0));
    chk("rst_errorCode", 512'(errorCode), 512'(0));
    chk("rst_idFull", 512'(idFull), 512'(0));
    chk("rst_idEmpty", 512'(idEmpty), 512'(1));
    resetN = 1'b1;
    tick();

    // Single 4-beat burst, master always ready
    push_id(4'd5);
    chk("t1_idEmpty_pre", 512'(idEmpty), 512'(0));
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 4'd5);
    cyc(1, 1, 0, 1, 1, 1, 0, 0, 4'd5);
    cyc(1, 2, 0, 1, 1, 1, 1, 0, 4'd5);
    cyc(1, 3, 1, 1, 1, 1, 2, 0, 4'd5);
    cyc(0, 0, 0, 1, 0, 1, 3, 1, 4'd5);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 4'd0);
    chk("t1_idEmpty_post", 512'(idEmpty), 512'(1));

    // Data with no outstanding master burst
    q_valid = 1'b1;
    q_data  = beat(99);
    #2;
    chk("t5_q_pop", 512'(q_pop), 512'(0));
    tick();
    chk("t5_errorCode", 512'(errorCode), 512'(2));
    chk("t5_m_rvalid", 512'(m_rvalid), 512'(0));
    q_valid = 1'b0;
    tick();
    chk("t5_errorCode_clear", 512'(errorCode), 512'(0));
    chk("t5_m_rvalid_after", 512'(m_rvalid), 512'(0));

    // Back-pressure: buffer fills at two beats, then drains at 1/cycle
    push_id(4'd6);
    cyc(1, 10, 0, 0, 1, 0, 0, 0, 4'd6);
    cyc(1, 11, 0, 0, 1, 1, 10, 0, 4'd6);
    cyc(1, 12, 0, 0, 0, 1, 10, 0, 4'd6);
    cyc(1, 12, 0, 0, 0, 1, 10, 0, 4'd6);
    cyc(1, 12, 0, 1, 0, 1, 10, 0, 4'd6);
    cyc(1, 12, 0, 1, 1, 1, 11, 0, 4'd6);
    cyc(1, 13, 1, 1, 1, 1, 12, 0, 4'd6);
    cyc(0, 0, 0, 1, 0, 1, 13, 1, 4'd6);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("t2_idEmpty_post", 512'(idEmpty), 512'(1));

    // Two back-to-back 2-beat bursts
    push_id(4'd1);
    push_id(4'd2);
    cyc(1, 20, 0, 1, 1, 0, 0, 0, 4'd1);
    cyc(1, 21, 1, 1, 1, 1, 20, 0, 4'd1);
    cyc(1, 22, 0, 1, 1, 1, 21, 1, 4'd1);
    cyc(1, 23, 1, 1, 1, 1, 22, 0, 4'd2);
    cyc(0, 0, 0, 1, 0, 1, 23, 1, 4'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("t3_idEmpty_post", 512'(idEmpty), 512'(1));

    // ID FIFO fill and overflow
    for (int i = 0; i < 8; i++) begin
      chk("t4_idFull_pre", 512'(idFull), 512'(0));
      push_id(4'(i));
    end
    chk("t4_idFull", 512'(idFull), 512'(1));
    ar_push = 1'b1;
    ar_id   = 4'd8;
    #2;
    chk("t4_err_before_ovf", 512'(errorCode), 512'(0));
    tick();
    ar_push = 1'b0;
    chk("t4_err_ovf", 512'(errorCode), 512'(1));
    cyc(1, 40, 1, 0, 1, 0, 0, 0, 4'd0);
    chk("t4_err_one_cycle", 512'(errorCode), 512'(0));
    // Push and pop together while full
    ar_push  = 1'b1;
    ar_id    = 4'd9;
    q_valid  = 1'b0;
    m_rready = 1'b1;
    #2;
    chk("t4_pp_m_rvalid", 512'(m_rvalid), 512'(1));
    chk("t4_pp_m_rlast", 512'(m_rlast), 512'(1));
    chk("t4_pp_m_rid", 512'(m_rid), 512'(0));
    chk("t4_pp_m_rdata", m_rdata, beat(40));
    tick();
    ar_push  = 1'b0;
    m_rready = 1'b0;
    chk("t4_pp_err", 512'(errorCode), 512'(0));
    chk("t4_pp_idFull", 512'(idFull), 512'(1));
    chk("t4_pp_m_rid_next", 512'(m_rid), 512'(1));
    chk("t4_pp_m_rvalid_after", 512'(m_rvalid), 512'(0));

    // Reset with two beats buffered
    cyc(1, 30, 0, 0, 1, 0, 0, 0, 4'd1);
    cyc(1, 31, 0, 0, 1, 1, 30, 0, 4'd1);
    q_valid = 1'b1;
    q_data  = beat(32);
    #2;
    chk("t6_full_q_pop", 512'(q_pop), 512'(0));
    chk("t6_full_m_rvalid", 512'(m_rvalid), 512'(1));
    resetN = 1'b0;
    #1;
    chk("t6_rst_m_rvalid", 512'(m_rvalid), 512'(0));
    chk("t6_rst_idEmpty", 512'(idEmpty), 512'(1));
    chk("t6_rst_idFull", 512'(idFull), 512'(0));
    chk("t6_rst_q_pop", 512'(q_pop), 512'(0));
    chk("t6_rst_m_rdata", m_rdata, 512'(0));
    chk("t6_rst_m_rid", 512'(m_rid), 512'(0));
    q_valid = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    chk("t6_post_m_rvalid", 512'(m_rvalid), 512'(0));
    chk("t6_post_idEmpty", 512'(idEmpty), 512'(1));
    chk("t6_post_q_pop", 512'(q_pop), 512'(0));
    chk("t6_post_errorCode", 512'(errorCode), 512'(0));

    // Recovery after reset
    push_id(4'd3);
    cyc(1, 50, 1, 1, 1, 0, 0, 0, 4'd3);
    cyc(0, 0, 0, 1, 0, 1, 50, 1, 4'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("t7_idEmpty", 512'(idEmpty), 512'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
